multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV64 subset datapath (R-type, ld, sd, beq). Sits directly upstream of the ALU control block.
- Sequences each instruction through fetch/decode/execute states and drives all datapath enables.
- Drives the aluOp1/aluOp0 pair consumed by ALU control: 00 = add, 01 = subtract/compare, 10 = decode from funct fields.
- Handshakes with a variable-latency memory via mem_ready.

Parameters:
- ILLEGAL_TRAP, 1: 1 = unsupported opcode parks the FSM in HALT until reset; 0 = the instruction is dropped and the FSM returns to FETCH.
- STATE_W, 4: width of the state register and the state debug output.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  7  instruction[6:0] from the instruction register (valid from DECODE onward).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by zero, applied by the datapath.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  write-back select: 1 = MDR, 0 = ALUOut.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU operand A select: 0 = PC, 1 = rs1.
- alu_src_b  out  2  ALU operand B select: 00 = rs2, 01 = const 4, 10 = immediate.
- pc_source  out  1  PC input select: 0 = ALU result, 1 = ALUOut.
- aluOp1  out  1  ALUOp high bit, to ALU control.
- aluOp0  out  1  ALUOp low bit, to ALU control.
- retire  out  1  one-cycle pulse on the final cycle of a completed instruction.
- illegal  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- state  out  STATE_W  current state, for debug.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset:
  - On a rising edge with reset=1, state <= FETCH.
  - While reset=1, every output is forced to 0 in that cycle, including mid-instruction and mid-memory-wait. Any pending memory access is abandoned.
- State encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, HALT=9.
  - Codes 10-15 go to FETCH on the next edge.
- Default output value is 0 unless a state lists it.
- FETCH:
  - Asserts mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, aluOp=00.
  - ir_write=pc_write=mem_ready (Mealy-gated); pc_source=0.
  - mem_ready=0: stay in FETCH. mem_ready=1: go to DECODE.
- DECODE:
  - Asserts alu_src_a=0, alu_src_b=10, aluOp=00 (branch target into ALUOut).
  - Next state by opcode:
    - 0000011 (ld) or 0100011 (sd) -> MEM_ADDR
    - 0110011 (R-type) -> EXECUTE
    - 1100011 (beq) -> BRANCH
    - any other opcode -> illegal=1; next state is HALT if ILLEGAL_TRAP=1, else FETCH.
- MEM_ADDR:
  - Asserts alu_src_a=1, alu_src_b=10, aluOp=00.
  - ld -> MEM_READ; sd -> MEM_WRITE.
  - Opcode is sampled in this state; the IR is stable because ir_write is only asserted in FETCH.
- MEM_READ: asserts mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: asserts reg_write=1, mem_to_reg=1, retire=1, then goes to FETCH.
- MEM_WRITE: asserts mem_write=1, i_or_d=1. Waits for mem_ready; retire=mem_ready; then goes to FETCH.
- EXECUTE: asserts alu_src_a=1, alu_src_b=00, aluOp=10, then goes to ALU_WB.
- ALU_WB: asserts reg_write=1, mem_to_reg=0, retire=1, then goes to FETCH.
- BRANCH:
  - Asserts alu_src_a=1, alu_src_b=00, aluOp=01, pc_write_cond=1, pc_source=1, retire=1, then goes to FETCH.
  - zero is not used by the FSM.
- HALT: all outputs 0; stays in HALT until reset.
- Latency with mem_ready=1 every cycle: ld=5, sd=4, R-type=4, beq=3 cycles. Each wait cycle adds one.
- Invariants:
  - mem_read and mem_write are never both 1.
  - reg_write is never 1 while mem_write=1.
  - Requests hold steady across wait cycles.

Decomposition:
- Shared package (rv_ctrl_pkg):
  - opcode constants OPC_RTYPE, OPC_LD, OPC_SD, OPC_BEQ
  - state enum/localparams
  - ALUOp codes ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - alu_src_b codes.
  ALU control imports the same ALUOp codes.
- Structure: a single module with a registered state process and a combinational next-state/output process. No sub-module.

Test Plan:
- R-type, mem_ready=1, opcode=0110011 -> states 0,1,6,7,0. aluOp=10 only in EXECUTE. reg_write and retire in cycle 4, mem_to_reg=0.
- ld with 2 wait cycles in both FETCH and MEM_READ -> FETCH held 3 cycles with ir_write=pc_write=0 until the mem_ready cycle. MEM_READ held 3 cycles. MEM_WB has reg_write=1, mem_to_reg=1. Total 9 cycles.
- sd, mem_ready=1, opcode=0100011 -> 0,1,2,5,0. mem_write=1, i_or_d=1 in state 5, retire there. reg_write is never 1.
- beq, opcode=1100011 -> BRANCH with aluOp=01, pc_write_cond=1, pc_source=1. Returns to FETCH after 3 cycles for both zero=0 and zero=1.
- opcode=1111111 -> illegal pulse in DECODE. ILLEGAL_TRAP=1: state=9 stays ≥10 cycles, then reset -> FETCH. ILLEGAL_TRAP=0: FETCH next cycle.
- reset asserted in MEM_READ during a wait -> all outputs 0 that cycle; state=0 next cycle; mem_read=1 with i_or_d=0 once reset drops.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the multicycle RV64 subset control path.
// Opcodes, FSM state codes, ALUOp and operand-B select encodings.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_SD    = 7'b0100011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_ALU_WB    = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_HALT      = 4'd9;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_source;
        logic [1:0] alu_op;
        logic       retire;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV64 subset datapath (R-type, ld, sd, beq).
// Registered state plus one combinational next-state / output process.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int ILLEGAL_TRAP = 1,
    parameter int STATE_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               pc_source,
    output logic               aluOp1,
    output logic               aluOp0,
    output logic               retire,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    ctrl_t      ctrl;
    ctrl_t      ctrl_o;

    // The branch decision is applied by the datapath, not by this FSM.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        ctrl    = '0;
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                state_d        = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                case (opcode)
                    OPC_LD, OPC_SD: state_d = S_MEM_ADDR;
                    OPC_RTYPE:      state_d = S_EXECUTE;
                    OPC_BEQ:        state_d = S_BRANCH;
                    default: begin
                        ctrl.illegal = 1'b1;
                        state_d = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d = (opcode == OPC_SD) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                state_d       = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.retire    = mem_ready;
                state_d        = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RS2;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 1'b1;
                ctrl.retire        = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Reset silences every output in the same cycle, abandoning any access.
    assign ctrl_o = reset ? '0 : ctrl;

    assign pc_write      = ctrl_o.pc_write;
    assign pc_write_cond = ctrl_o.pc_write_cond;
    assign i_or_d        = ctrl_o.i_or_d;
    assign mem_read      = ctrl_o.mem_read;
    assign mem_write     = ctrl_o.mem_write;
    assign ir_write      = ctrl_o.ir_write;
    assign mem_to_reg    = ctrl_o.mem_to_reg;
    assign reg_write     = ctrl_o.reg_write;
    assign alu_src_a     = ctrl_o.alu_src_a;
    assign alu_src_b     = ctrl_o.alu_src_b;
    assign pc_source     = ctrl_o.pc_source;
    assign aluOp1        = ctrl_o.alu_op[1];
    assign aluOp0        = ctrl_o.alu_op[0];
    assign retire        = ctrl_o.retire;
    assign illegal       = ctrl_o.illegal;
    assign state         = reset ? '0 : STATE_W'(state_q);

endmodule
